// File: rtl/digit_entry_pkg.sv
// rtl/digit_entry_pkg.sv - shared encodings and helpers for the keypad digit entry store
package digit_entry_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_CONV  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_BACKSPACE = 4'hE;
  localparam logic [3:0] DIGIT_MAX     = 4'd9;

  // 10^n, used to check that the binary output can hold the largest entry
  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/digit_entry_store_bcd_accum.sv
// rtl/digit_entry_store_bcd_accum.sv - iterative BCD to binary multiply-add datapath
module bcd_accum
  import digit_entry_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int VALUE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  start,
  input  logic                  step,
  input  logic [4*DIGITS-1:0]   digits,
  output logic [VALUE_W-1:0]    acc_next,
  output logic                  done
);

  logic [VALUE_W-1:0] acc;
  logic [1:0]         idx;
  logic [3:0]         digit;

  // Most significant digit first; unentered positions hold 0 and add nothing
  assign digit    = digits[4*idx +: 4];
  assign acc_next = VALUE_W'(({4'b0, acc} << 3) + ({4'b0, acc} << 1) + (VALUE_W+4)'(digit));
  // The step taking digit 0 is the final one
  assign done     = step && (idx == 2'd0);

  // Accumulator and digit index: clear aborts, start primes, step walks down
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      idx <= '0;
    end else if (clr) begin
      acc <= '0;
      idx <= '0;
    end else if (start) begin
      acc <= '0;
      idx <= 2'(DIGITS - 1);
    end else if (step) begin
      acc <= acc_next;
      idx <= idx - 2'd1;
    end
  end

endmodule

// File: rtl/digit_entry_store.sv
// rtl/digit_entry_store.sv - keypad number entry buffer with commit/clear and BCD conversion; option DIGIT_ENTRY_BACKSPACE_EN
module digit_entry_store
  import digit_entry_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int VALUE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  pressed,
  input  logic [3:0]            num_in,
  input  logic                  commit,
  input  logic                  clear,
  output logic [4*DIGITS-1:0]   digits_out,
  output logic [2:0]            count,
  output logic [VALUE_W-1:0]    value_out,
  output logic                  value_valid,
  output logic                  overflow,
  output logic [1:0]            state
);

  if (DIGITS < 1 || DIGITS > 4) begin : g_bad_digits
    $error("digit_entry_store: DIGITS must be 1..4");
  end
  if ((longint'(1) << VALUE_W) <= pow10(DIGITS) - 1) begin : g_bad_width
    $error("digit_entry_store: VALUE_W too narrow for DIGITS");
  end

  state_t             st;
  logic               do_commit;
  logic               do_press;
  logic               is_digit;
  logic [VALUE_W-1:0] acc_next;
  logic               acc_done;

  assign do_commit = enable && commit;
  assign do_press  = enable && pressed && !do_commit;
  assign is_digit  = (num_in <= DIGIT_MAX);
  assign state     = st;

  bcd_accum #(
    .DIGITS  (DIGITS),
    .VALUE_W (VALUE_W)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .clr      (clear),
    .start    (!clear && do_commit && st == S_ENTRY),
    .step     (!clear && st == S_CONV),
    .digits   (digits_out),
    .acc_next (acc_next),
    .done     (acc_done)
  );

  // Entry FSM with registered outputs; clear beats commit beats press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st          <= S_IDLE;
      digits_out  <= '0;
      count       <= '0;
      value_out   <= '0;
      value_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (clear) begin
        st          <= S_IDLE;
        digits_out  <= '0;
        count       <= '0;
        value_out   <= '0;
        value_valid <= 1'b0;
      end else begin
        case (st)
          S_IDLE, S_ENTRY: begin
            if (do_commit) begin
              if (st == S_ENTRY) st <= S_CONV;
            end else if (do_press && is_digit) begin
              if (count < 3'(DIGITS)) begin
                digits_out <= (digits_out << 4) | (4*DIGITS)'(num_in);
                count      <= count + 3'd1;
                st         <= S_ENTRY;
              end else begin
                overflow <= 1'b1;
              end
            end
`ifdef DIGIT_ENTRY_BACKSPACE_EN
            else if (do_press && num_in == KEY_BACKSPACE && st == S_ENTRY) begin
              digits_out <= digits_out >> 4;
              count      <= count - 3'd1;
              if (count == 3'd1) st <= S_IDLE;
            end
`endif
          end
          S_CONV: begin
            if (acc_done) begin
              value_out   <= acc_next;
              value_valid <= 1'b1;
              st          <= S_HOLD;
            end
          end
          S_HOLD: begin
            if (do_press && is_digit) begin
              digits_out  <= (4*DIGITS)'(num_in);
              count       <= 3'd1;
              value_out   <= '0;
              value_valid <= 1'b0;
              st          <= S_ENTRY;
            end
          end
          default: st <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_digit_entry_store.sv
// tb/tb_digit_entry_store.sv - directed self-checking bench for digit_entry_store
module tb_digit_entry_store;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       pressed = 1'b0;
  logic [3:0] num_in = 4'd0;
  logic       commit = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] digits_out;
  logic [2:0] count;
  logic [7:0] value_out;
  logic       value_valid;
  logic       overflow;
  logic [1:0] state;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  digit_entry_store #(.DIGITS(2), .VALUE_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pressed     (pressed),
    .num_in      (num_in),
    .commit      (commit),
    .clear       (clear),
    .digits_out  (digits_out),
    .count       (count),
    .value_out   (value_out),
    .value_valid (value_valid),
    .overflow    (overflow),
    .state       (state)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle key strobe; returns on the falling edge after the sampling edge
  task automatic press(input logic [3:0] d);
    @(negedge clk);
    pressed = 1'b1;
    num_in  = d;
    @(negedge clk);
    pressed = 1'b0;
  endtask

  task automatic pulse_commit();
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_state", state, 0);
    check("rst_digits", digits_out, 0);
    check("rst_count", count, 0);
    check("rst_value", value_out, 0);
    check("rst_valid", value_valid, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;

    // press ignored while disabled
    enable = 1'b0;
    press(4'd5);
    check("dis_count", count, 0);
    enable = 1'b1;

    // 4,7 then commit -> 47 after two conversion cycles
    press(4'd4);
    press(4'd7);
    check("47_digits", digits_out, 8'h47);
    check("47_count", count, 2);
    check("47_state", state, 1);
    pulse_commit();
    check("conv_c1", state, 2);
    @(negedge clk);
    check("conv_c2", state, 2);
    check("conv_valid_lo", value_valid, 0);
    @(negedge clk);
    check("hold_state", state, 3);
    check("hold_value", value_out, 47);
    check("hold_valid", value_valid, 1);

    // HOLD press starts a fresh entry
    press(4'd6);
    check("hp_state", state, 1);
    check("hp_digits", digits_out, 8'h06);
    check("hp_count", count, 1);
    check("hp_value", value_out, 0);
    check("hp_valid", value_valid, 0);

    // single digit, press during CONV ignored
    pulse_clear();
    press(4'd3);
    pulse_commit();
    check("c3_state", state, 2);
    pressed = 1'b1;
    num_in  = 4'd9;
    @(negedge clk);
    pressed = 1'b0;
    check("c3_ovf", overflow, 0);
    check("c3_digits", digits_out, 8'h03);
    @(negedge clk);
    check("c3_hold", state, 3);
    check("c3_value", value_out, 3);

    // full buffer rejects the third digit
    pulse_clear();
    press(4'd1);
    press(4'd2);
    press(4'd5);
    check("ovf_pulse", overflow, 1);
    check("ovf_digits", digits_out, 8'h12);
    check("ovf_count", count, 2);
    @(negedge clk);
    check("ovf_drop", overflow, 0);

    // clear wins over commit
    @(negedge clk);
    clear  = 1'b1;
    commit = 1'b1;
    @(negedge clk);
    clear  = 1'b0;
    commit = 1'b0;
    check("cc_state", state, 0);
    check("cc_digits", digits_out, 0);
    check("cc_valid", value_valid, 0);

    // asynchronous reset mid-conversion
    press(4'd1);
    pulse_commit();
    check("ar_conv", state, 2);
    #2 rst = 1'b1;
    #1;
    check("ar_state", state, 0);
    check("ar_digits", digits_out, 0);
    check("ar_count", count, 0);
    check("ar_value", value_out, 0);
    @(negedge clk);
    rst = 1'b0;

    // backspace code
    press(4'd8);
    press(4'd2);
    press(4'hE);
`ifdef DIGIT_ENTRY_BACKSPACE_EN
    check("bs_digits", digits_out, 8'h08);
    check("bs_count", count, 1);
    press(4'hE);
    check("bs_idle", state, 0);
    check("bs_count0", count, 0);
`else
    check("bs_digits", digits_out, 8'h82);
    check("bs_count", count, 2);
    press(4'hE);
    check("bs_state", state, 1);
    check("bs_ovf", overflow, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
